// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked integer execution unit with iterative multiply/divide
module seq_alu #(
    parameter int Width        = 32,
    parameter bit MulDivEnable = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] result,
    output logic [3:0]       status,
    output logic             illegal
);
    localparam int SW = $clog2(Width);
    localparam logic [SW-1:0] CNT_LAST = SW'(Width - 1);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [Width-1:0] hi_q, lo_q, opnd_q;
    logic [3:0]       op_q;
    logic [SW-1:0]    cnt_q;
    logic             qneg_q, rneg_q, bzero_q;

    logic             is_md_op, start_md, illegal_op;
    logic [Width:0]   sum, diff;
    logic [Width-1:0] sc_result;
    logic             sc_c, sc_v;
    logic [Width-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;

    logic [Width:0]   mul_add, div_sh, div_tr;
    logic             div_ge;
    logic [Width-1:0] hi_n, lo_n, md_result;

    assign is_md_op   = (op >= 4'd10);
    assign start_md   = MulDivEnable && is_md_op;
    assign illegal_op = !MulDivEnable && is_md_op;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs; nothing is accepted outside IDLE
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = start_md ? BUSY : DONE;
            end
            BUSY: if (cnt_q == '0) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle result and flags; carry/overflow only meaningful for ADD/SUB
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (op)
            4'd0: begin
                sc_result = sum[Width-1:0];
                sc_c      = sum[Width];
                sc_v      = (a[Width-1] == b[Width-1]) && (sum[Width-1] != a[Width-1]);
            end
            4'd1: begin
                sc_result = diff[Width-1:0];
                sc_c      = diff[Width];
                sc_v      = (a[Width-1] != b[Width-1]) && (diff[Width-1] != a[Width-1]);
            end
            4'd2: sc_result = a & b;
            4'd3: sc_result = a | b;
            4'd4: sc_result = a ^ b;
            4'd5: sc_result = {{(Width-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd6: sc_result = {{(Width-1){1'b0}}, (a < b)};
            4'd7: sc_result = a << b[SW-1:0];
            4'd8: sc_result = a >> b[SW-1:0];
            4'd9: sc_result = $unsigned($signed(a) >>> b[SW-1:0]);
            default: sc_result = '0;
        endcase
    end

    // Signed divide works on magnitudes; signs are restored after the last step
    always_comb begin
        a_neg = !op[0] && a[Width-1];
        b_neg = !op[0] && b[Width-1];
        a_mag = a_neg ? ({Width{1'b0}} - a) : a;
        b_mag = b_neg ? ({Width{1'b0}} - b) : b;
    end

    // One shift-add multiply step or one restoring divide step, plus final fixup
    always_comb begin
        mul_add = {1'b0, hi_q} + ({1'b0, opnd_q} & {(Width+1){lo_q[0]}});
        div_sh  = {hi_q, lo_q[Width-1]};
        div_tr  = div_sh - {1'b0, opnd_q};
        div_ge  = (div_sh >= {1'b0, opnd_q});
        if (!op_q[2]) begin
            hi_n = mul_add[Width:1];
            lo_n = {mul_add[0], lo_q[Width-1:1]};
        end else begin
            hi_n = div_ge ? div_tr[Width-1:0] : div_sh[Width-1:0];
            lo_n = {lo_q[Width-2:0], div_ge};
        end
        case (op_q)
            4'd10:   md_result = lo_n;
            4'd11:   md_result = hi_n;
            4'd12:   md_result = bzero_q ? '1 : (qneg_q ? ({Width{1'b0}} - lo_n) : lo_n);
            4'd13:   md_result = lo_n;
            4'd14:   md_result = rneg_q ? ({Width{1'b0}} - hi_n) : hi_n;
            4'd15:   md_result = hi_n;
            default: md_result = '0;
        endcase
    end

    // Operand capture, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            status  <= '0;
            illegal <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q <= op;
                    if (start_md) begin
                        illegal <= 1'b0;
                        cnt_q   <= CNT_LAST;
                        hi_q    <= '0;
                        if (!op[2]) begin
                            lo_q   <= b;
                            opnd_q <= a;
                        end else begin
                            lo_q   <= a_mag;
                            opnd_q <= b_mag;
                        end
                        qneg_q  <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        bzero_q <= (b == '0);
                    end else begin
                        result  <= sc_result;
                        status  <= {sc_result[Width-1], (sc_result == '0), sc_c, sc_v};
                        illegal <= illegal_op;
                    end
                end
                BUSY: begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        result <= md_result;
                        status <= {md_result[Width-1], (md_result == '0), 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, illegal;
    logic [3:0]  op, status;
    logic [31:0] a, b, result;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, illegal2;
    logic [3:0]  op2, status2;
    logic [31:0] a2, b2, result2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_alu #(.Width(32), .MulDivEnable(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .status(status), .illegal(illegal)
    );

    seq_alu #(.Width(32), .MulDivEnable(1'b0)) dut_nomd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op2), .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .result(result2), .status(status2), .illegal(illegal2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one op, wait for out_valid, check everything, then drain it
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res,
                          input logic [3:0] exp_st, input int exp_lat);
        int   lat;
        logic rdy_seen;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_seen = 1'b1;
        end while (!out_valid && lat < 200);
        check({tag, " result"}, result, exp_res);
        check({tag, " status"}, {28'd0, status}, {28'd0, exp_st});
        check({tag, " illegal"}, {31'd0, illegal}, 32'd0);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " in_ready low while busy"}, {31'd0, rdy_seen}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset status", {28'd0, status}, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;

        // Single-cycle ops
        run_op("add ovf",   4'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1001, 1);
        run_op("add carry", 4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b0110, 1);
        run_op("sub",       4'd1, 32'h1,         32'h2,         32'hFFFF_FFFF, 4'b1010, 1);
        run_op("xor",       4'd4, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 4'b1000, 1);
        run_op("sra",       4'd9, 32'h8000_0000, 32'h24,        32'hF800_0000, 4'b1000, 1);
        run_op("sll",       4'd7, 32'h1,         32'h3F,        32'h8000_0000, 4'b1000, 1);
        run_op("srl",       4'd8, 32'h8000_0000, 32'h1,         32'h4000_0000, 4'b0000, 1);
        run_op("sltu",      4'd6, 32'h1,         32'hFFFF_FFFF, 32'h1,         4'b0000, 1);
        run_op("slt",       4'd5, 32'h1,         32'hFFFF_FFFF, 32'h0,         4'b0100, 1);

        // Iterative multiply/divide
        run_op("mul",       4'd10, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 4'b1000, 33);
        run_op("mulhu",     4'd11, 32'hFFFF_FFFF, 32'h2,         32'h1,         4'b0000, 33);
        run_op("div",       4'd12, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 4'b1000, 33);
        run_op("rem",       4'd14, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 4'b1000, 33);
        run_op("divu by0",  4'd13, 32'h5,         32'h0,         32'hFFFF_FFFF, 4'b1000, 33);
        run_op("remu by0",  4'd15, 32'h5,         32'h0,         32'h5,         4'b0000, 33);
        run_op("div by0",   4'd12, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 4'b1000, 33);
        run_op("div ovf",   4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1000, 33);
        run_op("rem ovf",   4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         4'b0100, 33);
        run_op("divu",      4'd13, 32'd100,       32'd7,         32'd14,        4'b0000, 33);

        // Backpressure: result frozen, pending op ignored until drained
        @(negedge clk);
        op = 4'd0; a = 32'd20; b = 32'd22; in_valid = 1'b1;
        @(posedge clk);
        #1 op = 4'd1; a = 32'd10; b = 32'd3;
        @(negedge clk);
        check("bp first result", result, 32'd42);
        ok = out_valid;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || in_ready || result !== 32'd42) ok = 1'b0;
        end
        check("bp held stable", {31'd0, ok}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp idle after drain", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp next valid", {31'd0, out_valid}, 32'd1);
        check("bp next result", result, 32'd7);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the middle of a multiply
        @(negedge clk);
        op = 4'd10; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset no stale valid", {31'd0, out_valid}, 32'd0);
        run_op("add after reset", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 1);

        // Multiply/divide disabled configuration
        @(negedge clk);
        op2 = 4'd13; a2 = 32'd5; b2 = 32'd1; in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        @(negedge clk);
        check("nomd out_valid", {31'd0, out_valid2}, 32'd1);
        check("nomd illegal", {31'd0, illegal2}, 32'd1);
        check("nomd result", result2, 32'd0);
        check("nomd status", {28'd0, status2}, 32'h4);
        out_ready2 = 1'b1;
        @(posedge clk);
        #1 out_ready2 = 1'b0;
        @(negedge clk);
        op2 = 4'd0; a2 = 32'd9; b2 = 32'd1; in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        @(negedge clk);
        check("nomd add result", result2, 32'd10);
        check("nomd add illegal", {31'd0, illegal2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
